// File: rtl/usb_ep6_packet_scheduler_pkg.sv
// Shared encodings for the EP6 packet scheduler
// and the FX2 slave-FIFO controller.
package usb_sched_pkg;

  localparam int PKT_WORDS    = 256;
  localparam int IMG_PKTS_DEF = 1024;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PARAM,
    ST_IMAGE,
    ST_GAP
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_SYNC  = 2'd1,
    SRC_PARAM = 2'd2,
    SRC_IMAGE = 2'd3
  } src_e;

endpackage

// File: rtl/usb_ep6_packet_scheduler_if.sv
// Producer/controller side of the EP6 scheduler:
// request inputs, packet grant and frame status.
interface usb_ep6_packet_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             nframe;
  logic             ram_full;
  logic             ep6_ready;
  logic             pkt_done;
  logic             pkt_start;
  logic [1:0]       pkt_src;
  logic             select_flag;
  logic [CNT_W-1:0] img_pkt_cnt;
  logic             frame_active;
  logic             overrun;

  modport master (
    input  nframe, ram_full, ep6_ready, pkt_done,
    output pkt_start, pkt_src, select_flag,
    output img_pkt_cnt, frame_active, overrun
  );

  modport slave (
    output nframe, ram_full, ep6_ready, pkt_done,
    input  pkt_start, pkt_src, select_flag,
    input  img_pkt_cnt, frame_active, overrun
  );
endinterface

// File: rtl/usb_ep6_packet_scheduler.sv
// EP6 packet scheduler: grants sync, parameter and
// image packets one at a time, in frame order.
module usb_ep6_packet_scheduler
  import usb_sched_pkg::*;
#(
  parameter int IMG_PKTS = IMG_PKTS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic                  usb_clk,
  input logic                  rst,
  usb_ep6_packet_scheduler_if.master bus
);

  localparam logic [CNT_W-1:0] IMG_MAX = CNT_W'(IMG_PKTS);

  state_e           state_q, state_d;
  src_e             src_q, src_d;
  logic             start_q, start_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             ovr_q, ovr_d;
  logic             pend_q, pend_d;
  logic             param_q, param_d;

  logic             req_img;
  logic             sync_grant;
  logic [CNT_W-1:0] cnt_inc;

  // Image request: frame open, RAM half full, budget left.
  always_comb begin
    req_img = active_q & bus.ram_full & (cnt_q < IMG_MAX);
    cnt_inc = cnt_q + 1'b1;
  end

  // Next state: grant in IDLE, finish on pkt_done,
  // one settle cycle in GAP; frame request tracking.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    start_d    = 1'b0;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    ovr_d      = ovr_q;
    pend_d     = pend_q;
    param_d    = param_q;
    sync_grant = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.ep6_ready) begin
          if (pend_q) begin
            state_d    = ST_SYNC;
            src_d      = SRC_SYNC;
            start_d    = 1'b1;
            sync_grant = 1'b1;
            pend_d     = 1'b0;
            param_d    = 1'b1;
            active_d   = 1'b1;
            cnt_d      = '0;
            sel_d      = 1'b0;
          end else if (param_q) begin
            state_d = ST_PARAM;
            src_d   = SRC_PARAM;
            start_d = 1'b1;
          end else if (req_img) begin
            state_d = ST_IMAGE;
            src_d   = SRC_IMAGE;
            start_d = 1'b1;
          end
        end
      end
      ST_SYNC, ST_PARAM, ST_IMAGE: begin
        if (bus.pkt_done) begin
          state_d = ST_GAP;
          src_d   = SRC_NONE;
          if (state_q == ST_PARAM) begin
            param_d = 1'b0;
          end
          if (state_q == ST_IMAGE) begin
            sel_d = ~sel_q;
            if (cnt_q < IMG_MAX) begin
              cnt_d = cnt_inc;
            end
            if (cnt_inc == IMG_MAX) begin
              active_d = 1'b0;
            end
          end
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        src_d   = SRC_NONE;
      end
    endcase

    // A new frame wins over the sync grant consuming
    // the old one; a second request only flags overrun.
    if (bus.nframe) begin
      if (pend_q && !sync_grant) begin
        ovr_d = 1'b1;
      end
      pend_d = 1'b1;
    end
  end

  // State and counter registers.
  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      src_q    <= SRC_NONE;
      start_q  <= 1'b0;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      ovr_q    <= 1'b0;
      pend_q   <= 1'b0;
      param_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      start_q  <= start_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      ovr_q    <= ovr_d;
      pend_q   <= pend_d;
      param_q  <= param_d;
    end
  end

  assign bus.pkt_start    = start_q;
  assign bus.pkt_src      = src_q;
  assign bus.select_flag  = sel_q;
  assign bus.img_pkt_cnt  = cnt_q;
  assign bus.frame_active = active_q;
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_usb_ep6_packet_scheduler.sv
// Bench for usb_ep6_packet_scheduler: frame-level
// reference model feeding a start-event scoreboard.
module tb_usb_ep6_packet_scheduler;
  import usb_sched_pkg::*;

  localparam int IMG = 4;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic rst;

  usb_ep6_packet_scheduler_if #(.CNT_W(CW)) bus();

  usb_ep6_packet_scheduler #(
    .IMG_PKTS(IMG),
    .CNT_W   (CW)
  ) dut (
    .usb_clk(clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int src;
    int cnt;
    bit sel;
    bit act;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  // Frame-level model of what the block promises.
  bit m_pend, m_param, m_act, m_sel, m_ovr;
  int m_cnt;
  int cur_src;
  int g;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               name, got, want);
    end
  endtask

  // Scoreboard: every pkt_start must match a queued grant.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.pkt_start === 1'b1) begin
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_start: src %0d at cycle %0d, expected no start",
                 bus.pkt_src, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("start_src", 32'(bus.pkt_src), mon_e.src);
        chk("start_cnt", 32'(bus.img_pkt_cnt), mon_e.cnt);
        chk("start_sel", 32'(bus.select_flag), 32'(mon_e.sel));
        chk("start_active", 32'(bus.frame_active), 32'(mon_e.act));
        chk("start_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic nf_model(input bit nf, input bit sync_g);
    if (nf && m_pend && !sync_g) m_ovr = 1'b1;
    if (sync_g) m_pend = nf;
    else if (nf) m_pend = 1'b1;
  endtask

  task automatic model_reset();
    m_pend  = 0;
    m_param = 0;
    m_act   = 0;
    m_sel   = 0;
    m_ovr   = 0;
    m_cnt   = 0;
    cur_src = 0;
  endtask

  // One cycle with the block idle: predict the grant.
  task automatic step(input bit nf, input bit rdy,
                      input bit full, input bit dn,
                      output int gr);
    if (q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL grant_missing: %0d starts not seen, expected 0",
               q.size());
      q.delete();
    end
    bus.nframe    = nf;
    bus.ep6_ready = rdy;
    bus.ram_full  = full;
    bus.pkt_done  = dn;
    gr = 0;
    if (rdy) begin
      if (m_pend) gr = 1;
      else if (m_param) gr = 2;
      else if (m_act && full && m_cnt < IMG) gr = 3;
    end
    if (gr == 1) begin
      m_act   = 1;
      m_cnt   = 0;
      m_sel   = 0;
      m_param = 1;
    end
    nf_model(nf, gr == 1);
    if (gr != 0) q.push_back('{gr, m_cnt, m_sel, m_act, cyc + 1});
    cur_src = gr;
    tick();
  endtask

  // Act as the controller: len busy cycles, pkt_done, GAP.
  task automatic serve(input int len, input bit rnd,
                       input int nf_at);
    bit nf;
    for (int i = 0; i < len; i++) begin
      nf = (i == nf_at) || (rnd && $urandom_range(0, 29) == 0);
      bus.pkt_done  = 1'b0;
      bus.nframe    = nf;
      bus.ep6_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.ram_full  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      nf_model(nf, 1'b0);
      tick();
    end
    chk("src_hold", 32'(bus.pkt_src), cur_src);
    nf = rnd && $urandom_range(0, 19) == 0;
    bus.pkt_done = 1'b1;
    bus.nframe   = nf;
    nf_model(nf, 1'b0);
    if (cur_src == 2) m_param = 0;
    if (cur_src == 3) begin
      if (m_cnt < IMG) m_cnt++;
      m_sel = !m_sel;
      if (m_cnt == IMG) m_act = 0;
    end
    tick();
    chk("gap_src", 32'(bus.pkt_src), 0);
    chk("done_cnt", 32'(bus.img_pkt_cnt), m_cnt);
    chk("done_sel", 32'(bus.select_flag), 32'(m_sel));
    chk("done_active", 32'(bus.frame_active), 32'(m_act));
    chk("done_overrun", 32'(bus.overrun), 32'(m_ovr));
    nf = rnd && $urandom_range(0, 19) == 0;
    bus.pkt_done = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.nframe   = nf;
    nf_model(nf, 1'b0);
    cur_src = 0;
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    bus.nframe    = 1'b0;
    bus.ep6_ready = 1'b0;
    bus.ram_full  = 1'b0;
    bus.pkt_done  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_start", 32'(bus.pkt_start), 0);
    chk("rst_src", 32'(bus.pkt_src), 0);
    chk("rst_sel", 32'(bus.select_flag), 0);
    chk("rst_cnt", 32'(bus.img_pkt_cnt), 0);
    chk("rst_active", 32'(bus.frame_active), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    rst = 1'b0;
    tick();

    // No frame yet: nothing granted.
    repeat (3) step(0, 1, 1, 0, g);

    // Pending frame held off by ep6_ready.
    step(1, 0, 1, 0, g);
    repeat (4) step(0, 0, 1, 0, g);
    step(0, 1, 1, 0, g);
    serve(256, 0, -1);
    step(0, 1, 1, 0, g);
    serve(256, 0, -1);
    repeat (IMG) begin
      step(0, 1, 1, 0, g);
      serve(256, 0, -1);
    end
    chk("cnt_sat", 32'(bus.img_pkt_cnt), IMG);
    chk("active_off", 32'(bus.frame_active), 0);
    repeat (5) step(0, 1, 1, 0, g);
    chk("cnt_hold", 32'(bus.img_pkt_cnt), IMG);

    // nframe coincident with the sync grant.
    step(1, 1, 1, 0, g);
    step(1, 1, 1, 0, g);
    serve(3, 0, -1);
    chk("no_overrun", 32'(bus.overrun), 0);
    step(0, 1, 1, 0, g);
    serve(2, 0, -1);

    // nframe during image packet 2 pre-empts the frame.
    step(0, 1, 1, 0, g);
    serve(2, 0, -1);
    step(0, 1, 1, 0, g);
    serve(2, 0, -1);
    step(0, 1, 1, 0, g);
    serve(10, 0, 3);
    step(0, 1, 1, 0, g);
    serve(1, 0, -1);
    step(0, 1, 1, 0, g);
    serve(1, 0, -1);

    // Two frame pulses before the sync grant.
    step(1, 0, 0, 0, g);
    step(0, 0, 0, 0, g);
    step(1, 0, 0, 0, g);
    chk("overrun_set", 32'(bus.overrun), 1);
    step(0, 1, 0, 0, g);
    serve(1, 0, -1);
    step(0, 1, 0, 0, g);
    serve(1, 0, -1);
    repeat (3) step(0, 1, 0, 0, g);
    chk("overrun_sticky", 32'(bus.overrun), 1);

    // Reset in the middle of a parameter packet.
    step(1, 1, 0, 0, g);
    step(0, 1, 0, 0, g);
    serve(1, 0, -1);
    step(0, 1, 1, 0, g);
    bus.pkt_done = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("arst_start", 32'(bus.pkt_start), 0);
    chk("arst_src", 32'(bus.pkt_src), 0);
    chk("arst_sel", 32'(bus.select_flag), 0);
    chk("arst_cnt", 32'(bus.img_pkt_cnt), 0);
    chk("arst_active", 32'(bus.frame_active), 0);
    chk("arst_overrun", 32'(bus.overrun), 0);
    model_reset();
    q.delete();
    tick();
    rst = 1'b0;
    tick();
    repeat (6) step(0, 1, 1, 1'($urandom_range(0, 1)), g);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 14) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           1'($urandom_range(0, 1)), g);
      if (g != 0) serve($urandom_range(0, 6), 1, -1);
    end

    bus.nframe    = 1'b0;
    bus.ep6_ready = 1'b0;
    bus.pkt_done  = 1'b0;
    repeat (3) tick();
    if (q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL final_queue: %0d starts not seen, expected 0",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
